// File: rtl/uvmt_cv32e40x_achk_checker_if.sv
// Address-phase OBI bundle observed by the achk checker.
// Signals: req/gnt handshake, address-phase fields (addr, we, be, wdata,
// prot, memtype, dbg, atop), core-driven achk integrity bits and the
// response-phase rvalid.
// master: the side driving the bus (bench / initiator + memory model).
// slave : the checker, which only observes.
interface uvmt_cv32e40x_achk_checker_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [2:0]  prot;
  logic [1:0]  memtype;
  logic        dbg;
  logic [5:0]  atop;
  logic [11:0] achk;
  logic        rvalid;

  modport master (
    output req, gnt, addr, we, be, wdata, prot, memtype, dbg, atop, achk, rvalid
  );

  modport slave (
    input  req, gnt, addr, we, be, wdata, prot, memtype, dbg, atop, achk, rvalid
  );
endinterface

// File: rtl/uvmt_cv32e40x_achk_checker.sv
// Address-phase integrity (achk) checker for one cv32e40x OBI port.
// Recomputes the expected achk for each accepted request, flags mismatches
// inside integrity-enabled PMA regions, and queues a per-transfer failure
// flag so the response can be marked in order.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   obi (slave)         : observed address-phase bus and rvalid
//   achk_err_o          : registered pulse, one per failed accepted transfer
//   resp_achk_err_o     : combinational, rvalid && FIFO head failed
//   err_cnt_o           : saturating failure count
//   first_err_addr_o    : address of first failure since reset
//   sticky_err_o        : set on first failure
//   proto_err_o         : sticky FIFO overflow / underflow flag

package uvmt_cv32e40x_achk_pkg;
  typedef struct packed {
    logic [31:0] word_addr_low;
    logic [31:0] word_addr_high;
    logic        main;
    logic        bufferable;
    logic        cacheable;
    logic        integrity;
  } pma_cfg_t;

  // Attributes for addresses not covered by any configured region.
  localparam pma_cfg_t PMA_R_DEFAULT = '{
    word_addr_low: '0, word_addr_high: '0,
    main: 1'b0, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b0
  };

  // Attributes used everywhere when no regions are configured.
  localparam pma_cfg_t NO_PMA_R_DEFAULT = '{
    word_addr_low: '0, word_addr_high: '0,
    main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b0
  };
endpackage

module uvmt_cv32e40x_achk_checker
  import uvmt_cv32e40x_achk_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int          PMA_NUM_REGIONS = 0,
  parameter pma_cfg_t    PMA_CFG [PMA_NUM_REGIONS-1:0] = '{default: PMA_R_DEFAULT},
  parameter logic [31:0] DM_REGION_START = 32'hF000_0000,
  parameter logic [31:0] DM_REGION_END   = 32'hF000_3FFF
) (
  input  logic        clk,
  input  logic        rst,
  uvmt_cv32e40x_achk_checker_if.slave obi,
  output logic        achk_err_o,
  output logic        resp_achk_err_o,
  output logic [15:0] err_cnt_o,
  output logic [31:0] first_err_addr_o,
  output logic        sticky_err_o,
  output logic        proto_err_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
  logic [PTR_W-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       achk_err_q, achk_err_d;
  logic [15:0]                err_cnt_q, err_cnt_d;
  logic [31:0]                first_err_addr_q, first_err_addr_d;
  logic                       sticky_q, sticky_d;
  logic                       proto_q, proto_d;

  logic [11:0] exp_achk;
  logic [11:0] cmp_mask;
  logic        mismatch;
  logic [31:0] word_addr;
  logic        region_hit;
  logic        region_integrity;
  logic        dm_access;
  logic        has_integrity;
  logic        accept;
  logic        fail;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Expected check bits (even parity per field group).
  always_comb begin
    exp_achk[0]  = ^obi.addr[7:0];
    exp_achk[1]  = ^obi.addr[15:8];
    exp_achk[2]  = ^obi.addr[23:16];
    exp_achk[3]  = ^obi.addr[31:24];
    exp_achk[4]  = ^{obi.prot, obi.memtype};
    exp_achk[5]  = ^{obi.be, obi.we};
    exp_achk[6]  = obi.dbg;
    exp_achk[7]  = ^obi.atop;
    exp_achk[8]  = ^obi.wdata[7:0];
    exp_achk[9]  = ^obi.wdata[15:8];
    exp_achk[10] = ^obi.wdata[23:16];
    exp_achk[11] = ^obi.wdata[31:24];
    // Write-data parity only carries meaning on writes.
    cmp_mask     = obi.we ? 12'hFFF : 12'h0FF;
    mismatch     = |((obi.achk ^ exp_achk) & cmp_mask);
  end

  // PMA lookup: lowest-index region with low <= word_addr < high wins.
  always_comb begin
    word_addr        = {2'b00, obi.addr[31:2]};
    region_hit       = 1'b0;
    region_integrity = (PMA_NUM_REGIONS == 0) ? NO_PMA_R_DEFAULT.integrity
                                              : PMA_R_DEFAULT.integrity;
    for (int unsigned i = 0; i < unsigned'(PMA_NUM_REGIONS); i++) begin
      if (!region_hit &&
          (word_addr >= PMA_CFG[i].word_addr_low) &&
          (word_addr <  PMA_CFG[i].word_addr_high)) begin
        region_hit       = 1'b1;
        region_integrity = PMA_CFG[i].integrity;
      end
    end
    dm_access     = obi.dbg && (obi.addr >= DM_REGION_START) && (obi.addr <= DM_REGION_END);
    has_integrity = region_integrity && !dm_access;
  end

  assign accept = obi.req && obi.gnt;
  assign fail   = accept && has_integrity && mismatch;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == CNT_W'(MAX_OUTSTANDING));
  assign pop    = obi.rvalid && !empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still
  // accepts the push; only a push into a full FIFO with no pop overflows.
  assign push   = accept && (!full || pop);

  always_comb begin
    fifo_d           = fifo_q;
    wptr_d           = wptr_q;
    rptr_d           = rptr_q;
    cnt_d            = cnt_q;
    achk_err_d       = fail;
    err_cnt_d        = err_cnt_q;
    first_err_addr_d = first_err_addr_q;
    sticky_d         = sticky_q;
    proto_d          = proto_q;

    if (push) begin
      fifo_d[wptr_q] = fail;
      wptr_d = (wptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rptr_q + PTR_W'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    if ((accept && !push) || (obi.rvalid && empty)) begin
      proto_d = 1'b1;
    end

    if (fail && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
    if (fail && !sticky_q) begin
      first_err_addr_d = obi.addr;
      sticky_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_q           <= '0;
      wptr_q           <= '0;
      rptr_q           <= '0;
      cnt_q            <= '0;
      achk_err_q       <= 1'b0;
      err_cnt_q        <= '0;
      first_err_addr_q <= '0;
      sticky_q         <= 1'b0;
      proto_q          <= 1'b0;
    end else begin
      fifo_q           <= fifo_d;
      wptr_q           <= wptr_d;
      rptr_q           <= rptr_d;
      cnt_q            <= cnt_d;
      achk_err_q       <= achk_err_d;
      err_cnt_q        <= err_cnt_d;
      first_err_addr_q <= first_err_addr_d;
      sticky_q         <= sticky_d;
      proto_q          <= proto_d;
    end
  end

  assign resp_achk_err_o  = obi.rvalid && !empty && fifo_q[rptr_q];
  assign achk_err_o       = achk_err_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_addr_q;
  assign sticky_err_o     = sticky_q;
  assign proto_err_o      = proto_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_achk_checker.sv
// Self-checking bench for uvmt_cv32e40x_achk_checker: directed scenarios
// plus randomized traffic compared against a queue-based reference model.
module tb_uvmt_cv32e40x_achk_checker;
  import uvmt_cv32e40x_achk_pkg::*;

  localparam int unsigned MAXO = 2;

  // Region 0: integrity, bytes 0x0000_0000..0x3FFF_FFFF
  // Region 1: no integrity, bytes 0x2000_0000..0x7FFF_FFFF (overlaps region 0)
  // Region 2: integrity, bytes 0xF000_0000..0xFFFF_FFFF
  localparam pma_cfg_t TB_PMA [2:0] = '{
    '{word_addr_low: 32'h3C00_0000, word_addr_high: 32'h4000_0000,
      main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b1},
    '{word_addr_low: 32'h0800_0000, word_addr_high: 32'h2000_0000,
      main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b0},
    '{word_addr_low: 32'h0000_0000, word_addr_high: 32'h1000_0000,
      main: 1'b1, bufferable: 1'b0, cacheable: 1'b0, integrity: 1'b1}
  };

  logic        clk;
  logic        rst;
  logic        achk_err;
  logic        resp_achk_err;
  logic [15:0] err_cnt;
  logic [31:0] first_err_addr;
  logic        sticky_err;
  logic        proto_err;

  uvmt_cv32e40x_achk_checker_if obi();

  uvmt_cv32e40x_achk_checker #(
    .MAX_OUTSTANDING (MAXO),
    .PMA_NUM_REGIONS (3),
    .PMA_CFG         (TB_PMA),
    .DM_REGION_START (32'hF000_0000),
    .DM_REGION_END   (32'hF000_3FFF)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .obi              (obi),
    .achk_err_o       (achk_err),
    .resp_achk_err_o  (resp_achk_err),
    .err_cnt_o        (err_cnt),
    .first_err_addr_o (first_err_addr),
    .sticky_err_o     (sticky_err),
    .proto_err_o      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          mq[$];
  int          m_cnt;
  logic [31:0] m_first;
  bit          m_sticky;
  bit          m_proto;
  bit          m_pulse;

  function automatic bit par(input logic [31:0] v);
    return bit'($countones(v) % 2);
  endfunction

  function automatic logic [11:0] m_achk(input logic [31:0] a, input logic w, input logic [3:0] b,
                                         input logic [31:0] wd, input logic [2:0] p,
                                         input logic [1:0] mt, input logic d, input logic [5:0] at);
    logic [11:0] r;
    for (int k = 0; k < 4; k++) begin
      r[k]   = par((a  >> (8*k)) & 32'hFF);
      r[k+8] = par((wd >> (8*k)) & 32'hFF);
    end
    r[4] = par({27'd0, p, mt});
    r[5] = par({27'd0, b, w});
    r[6] = d;
    r[7] = par({26'd0, at});
    return r;
  endfunction

  function automatic bit m_integ(input logic [31:0] a, input logic d);
    if (d && a >= 32'hF000_0000 && a <= 32'hF000_3FFF) return 1'b0;
    return (a < 32'h4000_0000) || (a >= 32'hF000_0000);
  endfunction

  function automatic bit m_fail();
    logic [11:0] g;
    bit bad;
    g   = m_achk(obi.addr, obi.we, obi.be, obi.wdata, obi.prot, obi.memtype, obi.dbg, obi.atop);
    bad = (obi.achk[7:0] != g[7:0]) || (obi.we && (obi.achk[11:8] != g[11:8]));
    return obi.req && obi.gnt && m_integ(obi.addr, obi.dbg) && bad;
  endfunction

  task automatic model_edge();
    bit f;
    if (rst) begin
      mq.delete(); m_cnt = 0; m_first = '0; m_sticky = 0; m_proto = 0; m_pulse = 0;
      return;
    end
    f = m_fail();
    if (obi.rvalid) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else m_proto = 1;
    end
    if (obi.req && obi.gnt) begin
      if (mq.size() < MAXO) mq.push_back(f);
      else m_proto = 1;
    end
    m_pulse = f;
    if (f && m_cnt < 65535) m_cnt++;
    if (f && !m_sticky) begin
      m_sticky = 1;
      m_first  = obi.addr;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    obi.req = 0; obi.gnt = 0; obi.addr = '0; obi.we = 0; obi.be = '0; obi.wdata = '0;
    obi.prot = '0; obi.memtype = '0; obi.dbg = 0; obi.atop = '0; obi.achk = '0;
  endtask

  task automatic txn(input logic [31:0] a, input logic w, input logic d, input logic [11:0] flip);
    obi.req = 1; obi.gnt = 1; obi.addr = a; obi.we = w; obi.dbg = d;
    obi.be = 4'($urandom); obi.wdata = $urandom; obi.prot = 3'($urandom);
    obi.memtype = 2'($urandom); obi.atop = 6'($urandom);
    obi.achk = m_achk(a, w, obi.be, obi.wdata, obi.prot, obi.memtype, d, obi.atop) ^ flip;
  endtask

  // Called just after a falling edge with inputs driven; returns after the
  // next falling edge.
  task automatic step();
    bit exp_resp;
    #1;
    exp_resp = !rst && obi.rvalid && (mq.size() > 0) && mq[0];
    if (rst) exp_resp = obi.rvalid && (mq.size() > 0) && mq[0];
    if (chk_en) check_eq("resp_achk_err", 32'(resp_achk_err), 32'(exp_resp));
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) begin
      check_eq("achk_err",       32'(achk_err),   32'(m_pulse));
      check_eq("err_cnt",        32'(err_cnt),    32'(m_cnt));
      check_eq("first_err_addr", first_err_addr,  m_first);
      check_eq("sticky_err",     32'(sticky_err), 32'(m_sticky));
      check_eq("proto_err",      32'(proto_err),  32'(m_proto));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; idle(); obi.rvalid = 0;
    step();
    rst = 0;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] tbl [9];
    tbl = '{32'h0000_1000, 32'h3FFF_FFFC, 32'h4000_0000, 32'h7FFF_FFFC, 32'h8000_0000,
            32'hEFFF_FFFC, 32'hF000_0000, 32'hF000_3FFF, 32'hF000_4000};
    if ($urandom_range(0, 3) == 0) return $urandom;
    return tbl[$urandom_range(0, 8)];
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst = 1; idle(); obi.rvalid = 0;
    @(negedge clk);
    step();
    step();
    check_eq("reset_err_cnt", 32'(err_cnt), 32'd0);
    check_eq("reset_sticky",  32'(sticky_err), 32'd0);
    rst = 0;

    // Two good reads, responses three cycles later.
    txn(32'h0000_1000, 0, 0, 12'h000); step();
    txn(32'h0000_1000, 0, 0, 12'h000); step();
    idle(); step(); step();
    obi.rvalid = 1; step(); step();
    obi.rvalid = 0; step();
    check_eq("good_reads_cnt",   32'(err_cnt),   32'd0);
    check_eq("good_reads_proto", 32'(proto_err), 32'd0);

    // Bad write in an integrity region.
    txn(32'h2000_0004, 1, 0, 12'h200); step();
    check_eq("badw_pulse", 32'(achk_err), 32'd1);
    check_eq("badw_cnt",   32'(err_cnt), 32'd1);
    check_eq("badw_addr",  first_err_addr, 32'h2000_0004);
    idle(); obi.rvalid = 1;
    #1 check_eq("badw_resp", 32'(resp_achk_err), 32'd1);
    step(); obi.rvalid = 0;

    // Same corruption where integrity is off, dbg access in DM, and a read
    // with corrupted write-data parity: none count.
    txn(32'h4000_0010, 1, 0, 12'h200); step(); idle(); obi.rvalid = 1; step(); obi.rvalid = 0;
    txn(32'hF000_0100, 1, 1, 12'h200); step(); idle(); obi.rvalid = 1; step(); obi.rvalid = 0;
    txn(32'h0000_1000, 0, 0, 12'hF00); step(); idle(); obi.rvalid = 1; step(); obi.rvalid = 0;
    check_eq("noerr_cnt", 32'(err_cnt), 32'd1);

    // good/bad/good interleaved with responses (push+pop cycles).
    txn(32'h0000_2000, 0, 0, 12'h000); obi.rvalid = 0; step();
    txn(32'h0000_2004, 0, 0, 12'h001); obi.rvalid = 1;
    #1 check_eq("gbg_resp0", 32'(resp_achk_err), 32'd0);
    step();
    txn(32'h0000_2008, 0, 0, 12'h000); obi.rvalid = 1;
    #1 check_eq("gbg_resp1", 32'(resp_achk_err), 32'd1);
    step();
    idle(); obi.rvalid = 1;
    #1 check_eq("gbg_resp2", 32'(resp_achk_err), 32'd0);
    step(); obi.rvalid = 0;

    // Overflow: third handshake with two outstanding.
    txn(32'h0000_3000, 0, 0, 12'h000); step();
    txn(32'h0000_3004, 0, 0, 12'h000); step();
    check_eq("pre_ovf_proto", 32'(proto_err), 32'd0);
    txn(32'h0000_3008, 0, 0, 12'h000); step();
    check_eq("ovf_proto", 32'(proto_err), 32'd1);

    // Underflow: rvalid on an empty FIFO.
    do_reset();
    idle(); obi.rvalid = 1;
    #1 check_eq("udf_resp", 32'(resp_achk_err), 32'd0);
    step(); obi.rvalid = 0;
    check_eq("udf_proto", 32'(proto_err), 32'd1);

    // Reset with two failing entries outstanding.
    do_reset();
    txn(32'h0000_4000, 1, 0, 12'h010); step();
    txn(32'h0000_4004, 1, 0, 12'h010); step();
    rst = 1; idle(); step(); rst = 0;
    check_eq("rst_mid_cnt",    32'(err_cnt), 32'd0);
    check_eq("rst_mid_sticky", 32'(sticky_err), 32'd0);
    check_eq("rst_mid_addr",   first_err_addr, 32'd0);
    obi.rvalid = 1;
    #1 check_eq("rst_mid_empty_resp", 32'(resp_achk_err), 32'd0);
    step(); obi.rvalid = 0;

    // Randomized traffic.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [11:0] flip;
      flip = ($urandom_range(0, 2) == 0) ? (12'h001 << $urandom_range(0, 11)) : 12'h000;
      txn(pick_addr(), 1'($urandom), 1'($urandom), flip);
      obi.req    = ($urandom_range(0, 3) != 0);
      obi.gnt    = ($urandom_range(0, 3) != 0);
      obi.rvalid = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;

    // Saturation of the error counter.
    do_reset();
    chk_en = 0;
    for (int n = 0; n < 65540; n++) begin
      txn(32'h0000_5000, 1, 0, 12'h040);
      obi.rvalid = 1;
      step();
    end
    chk_en = 1;
    txn(32'h0000_5000, 1, 0, 12'h040); obi.rvalid = 1; step();
    check_eq("sat_cnt", 32'(err_cnt), 32'h0000_FFFF);
    idle(); obi.rvalid = 0; step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uvmt_cv32e40x_achk_checker.md
# uvmt_cv32e40x_achk_checker

Address-phase integrity checker for one cv32e40x OBI port (instruction or data), placed in the testbench between the core's OBI initiator and the memory model. It recomputes the expected `achk` for every accepted request and compares it with the `achk` driven by the core. Mismatches count as errors only in integrity-enabled PMA regions. The checker keeps an in-order FIFO of per-transaction failure flags so the memory model can return `err` on the matching response, and it exposes error counters for the scoreboard.

## Interface
- `MAX_OUTSTANDING`, 2: FIFO depth; maximum in-flight transfers.
- `PMA_NUM_REGIONS`, 0: number of PMA regions; 0 means `NO_PMA_R_DEFAULT` applies to every address.
- `PMA_CFG`, `'{default:PMA_R_DEFAULT}`: region table; regions are word-addressed and first match at the lowest index wins.
- `DM_REGION_START` / `DM_REGION_END`, `32'hF0000000` / `32'hF0003FFF`: inclusive debug module range.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_i`, `gnt_i` in 1: address-phase handshake; a transfer is accepted when both are 1.
- `addr_i` in 32, `we_i` in 1, `be_i` in 4, `wdata_i` in 32, `prot_i` in 3, `memtype_i` in 2, `dbg_i` in 1, `atop_i` in 6: address-phase fields.
- `achk_i` in 12: integrity bits driven by the core.
- `rvalid_i` in 1: response-phase valid (pop).
- `achk_err_o` out 1: registered one-cycle pulse for a failed accepted transfer.
- `resp_achk_err_o` out 1: combinational; asserted with `rvalid_i` when the FIFO head failed.
- `err_cnt_o` out 16: saturating count of failed transfers.
- `first_err_addr_o` out 32: `addr_i` of the first failure since reset.
- `sticky_err_o` out 1: set on the first failure.
- `proto_err_o` out 1: sticky flag for FIFO overflow or underflow.

## Operation
- Expected check bits use even parity (`^`):
  - [0]..[3] = `addr_i` bytes 0..3
  - [4] = `{prot_i, memtype_i}`
  - [5] = `{be_i, we_i}`
  - [6] = `dbg_i`
  - [7] = `atop_i`
  - [8]..[11] = `wdata_i` bytes 0..3
- Bits [11:8] are compared only when `we_i`=1 and are ignored on reads.
- `has_integrity`:
  - The PMA region of `{2'b00, addr_i[31:2]}` supplies the `integrity` attribute; if no region matches, `PMA_R_DEFAULT` applies.
  - `has_integrity` is forced to 0 when `dbg_i`=1 and `DM_REGION_START` <= `addr_i` <= `DM_REGION_END`.
- `fail` = `req_i && gnt_i && has_integrity && (achk_i != expected)`, with the bit masking above applied.
- FIFO:
  - Holds `MAX_OUTSTANDING` 1-bit entries, in order, using read/write pointers that wrap modulo depth plus an occupancy count of width `$clog2(MAX_OUTSTANDING+1)`.
  - Push `fail` on every accepted transfer; pop on `rvalid_i`.
  - Push and pop in the same cycle on a non-empty FIFO: both happen and the count is unchanged.
  - Push when full: the entry is dropped, the count holds, and `proto_err_o` is set.
  - Pop when empty, including a same-cycle push into an empty FIFO: nothing is popped, `resp_achk_err_o`=0, and `proto_err_o` is set. In that same-cycle case the push still occurs.
- `resp_achk_err_o` = `rvalid_i && !empty && head`.
- Counters:
  - `err_cnt_o` increments on `fail` and saturates at `16'hFFFF`.
  - `first_err_addr_o` and `sticky_err_o` load only when `fail` occurs and `sticky_err_o`=0.

## Timing
- Reset values: all outputs 0, FIFO empty, pointers 0.
- Reset asserted mid-operation clears everything on the next edge; in-flight entries are discarded.
- `achk_err_o`, `err_cnt_o`, `first_err_addr_o`, `sticky_err_o` and `proto_err_o` update on the edge after the handshake, giving a latency of 1.
- An entry pushed in cycle N is poppable from cycle N+1.
- `resp_achk_err_o` has zero latency with respect to `rvalid_i`.
- Back-to-back failing handshakes produce back-to-back `achk_err_o` pulses and increment the count by 1 per cycle.

## Test plan
- Correct `achk_i` on a read at `addr_i`=`32'h0000_1000` in an integrity region; 2 transfers; responses 3 cycles later -> all error outputs stay 0 and the FIFO drains to empty.
- Write at `32'h2000_0004` with `achk_i[9]` flipped in an integrity region -> `achk_err_o` pulses 1 cycle later, `err_cnt_o`=1, `first_err_addr_o`=`32'h2000_0004`, and `resp_achk_err_o`=1 on its `rvalid_i`.
- The same corruption in a non-integrity region, and on a `dbg_i`=1 access to `32'hF000_0100` -> no error. A read with `achk_i[11:8]` corrupted -> no error.
- `MAX_OUTSTANDING`=2, sequence good/bad/good with responses interleaved with handshakes, including a simultaneous push+pop -> `resp_achk_err_o` pattern is 0,1,0.
- Third handshake with 2 outstanding and no `rvalid_i` -> `proto_err_o`=1. Separately, `rvalid_i` while the FIFO is empty -> `proto_err_o`=1 and `resp_achk_err_o`=0.
- 65536 failing handshakes -> `err_cnt_o` holds `16'hFFFF`. Reset asserted with 2 entries outstanding -> all outputs 0 and FIFO empty on the next edge.
